// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and
// the legal/default operand width.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 32;
    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when non-negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, divisor_i};
        // Top bit of the WIDTH+1 wide difference is the borrow.
        if (!trial[WIDTH]) begin
            rem_o  = trial[WIDTH-1:0];
            qbit_o = 1'b1;
        end else begin
            rem_o  = shifted[WIDTH-1:0];
            qbit_o = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, WIDTH steps per operation, start/busy/done
// handshake. Define SEQ_DIVIDER_SIGNED_EN to add the is_signed port.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("seq_divider: WIDTH out of range");
    end

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] x,
                                                   input logic neg);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             signed_sel;
    logic             sgn_u, sgn_v;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign signed_sel = is_signed;
`else
    assign signed_sel = 1'b0;
`endif

    assign sgn_u = signed_sel & dividend[WIDTH-1];
    assign sgn_v = signed_sel & divisor[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[WIDTH-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Divide magnitudes; signs are restored on completion.
                    state_d = CALC;
                    cnt_d   = CNT_INIT;
                    rem_d   = '0;
                    quo_d   = negate_if(dividend, sgn_u);
                    div_d   = negate_if(divisor, sgn_v);
                    negq_d  = sgn_u ^ sgn_v;
                    negr_d  = sgn_u;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    dbz_d       = (div_q == '0);
                    quotient_d  = (div_q == '0) ? '1
                                : negate_if({quo_q[WIDTH-2:0], step_qbit}, negq_q);
                    remainder_d = negate_if(step_rem, negr_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Working datapath registers are always reloaded on acceptance.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        div_q  <= div_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8) with a behavioural model.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic         is_signed = 1'b0;
`endif
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: integer division from the arithmetic rules.
    function automatic void ref_div(input logic [W-1:0] u, input logic [W-1:0] v,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic z);
        int su, sv;
        z = (v == 0);
        if (v == 0) begin
            q = '1;
            r = u;
        end else if (s) begin
            su = $signed(u);
            sv = $signed(v);
            q = W'(su / sv);
            r = W'(su % sv);
        end else begin
            q = u / v;
            r = u % v;
        end
    endfunction

    task automatic start_op(input logic [W-1:0] u, input logic [W-1:0] v, input logic s);
        @(negedge clk);
        dividend = u;
        divisor  = v;
`ifdef SEQ_DIVIDER_SIGNED_EN
        is_signed = s;
`else
        if (s) $display("note: signed request ignored in unsigned build");
`endif
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done(output int nbusy, output logic seen_done);
        nbusy = 0;
        while (busy && nbusy < 4 * W) begin
            nbusy++;
            @(negedge clk);
        end
        seen_done = done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (quotient !== '0) begin n_fail++; $display("FAIL reset_quo got %h want 0", quotient); end
        if (remainder !== '0) begin n_fail++; $display("FAIL reset_rem got %h want 0", remainder); end
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] us [5] = '{8'd100, 8'd5, 8'd0, 8'd255, 8'd7};
        logic [W-1:0] vs [5] = '{8'd7, 8'd0, 8'd3, 8'd1, 8'd9};
        logic [W-1:0] eq, er;
        logic ez, sd;
        int nb;
        for (int i = 0; i < 5; i++) begin
            ref_div(us[i], vs[i], 1'b0, eq, er, ez);
            start_op(us[i], vs[i], 1'b0);
            wait_done(nb, sd);
            n_checks += 6;
            if (nb !== W) begin n_fail++; $display("FAIL dir%0d_latency busy %0d cycles want %0d", i, nb, W); end
            if (sd !== 1'b1) begin n_fail++; $display("FAIL dir%0d_done got %b want 1", i, sd); end
            if (quotient !== eq) begin n_fail++; $display("FAIL dir%0d_quo got %h want %h", i, quotient, eq); end
            if (remainder !== er) begin n_fail++; $display("FAIL dir%0d_rem got %h want %h", i, remainder, er); end
            if (div_by_zero !== ez) begin n_fail++; $display("FAIL dir%0d_dbz got %b want %b", i, div_by_zero, ez); end
            @(negedge clk);
            if (done !== 1'b0 || quotient !== eq) begin
                n_fail++;
                $display("FAIL dir%0d_hold done %b quo %h want 0 %h", i, done, quotient, eq);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        logic sd;
        start_op(8'd255, 8'd1, 1'b0);
        wait_done(nb, sd);
        dividend = 8'd7;
        divisor  = 8'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks += 3;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept busy %b want 1", busy); end
        if (quotient !== 8'd255) begin n_fail++; $display("FAIL b2b_first_quo got %h want ff", quotient); end
        if (remainder !== 8'd0) begin n_fail++; $display("FAIL b2b_first_rem got %h want 00", remainder); end
        wait_done(nb, sd);
        n_checks += 4;
        if (nb !== W) begin n_fail++; $display("FAIL b2b_latency busy %0d want %0d", nb, W); end
        if (sd !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", sd); end
        if (quotient !== 8'd0) begin n_fail++; $display("FAIL b2b_quo got %h want 00", quotient); end
        if (remainder !== 8'd7) begin n_fail++; $display("FAIL b2b_rem got %h want 07", remainder); end
    endtask

    task automatic test_start_ignored();
        int nb;
        logic sd;
        start_op(8'd100, 8'd7, 1'b0);
        repeat (2) @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, sd);
        n_checks += 4;
        if (nb + 3 !== W) begin n_fail++; $display("FAIL ign_latency busy %0d want %0d", nb + 3, W); end
        if (sd !== 1'b1) begin n_fail++; $display("FAIL ign_done got %b want 1", sd); end
        if (quotient !== 8'd14) begin n_fail++; $display("FAIL ign_quo got %h want 0e", quotient); end
        if (remainder !== 8'd2) begin n_fail++; $display("FAIL ign_rem got %h want 02", remainder); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle busy %b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        int nb;
        logic sd;
        start_op(8'd5, 8'd0, 1'b0);
        wait_done(nb, sd);
        start_op(8'd200, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        if (quotient !== '0) begin n_fail++; $display("FAIL rst_quo got %h want 0", quotient); end
        if (remainder !== '0) begin n_fail++; $display("FAIL rst_rem got %h want 0", remainder); end
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dbz got %b want 0", div_by_zero); end
        @(negedge clk);
        reset = 1'b0;
        start_op(8'd9, 8'd3, 1'b0);
        wait_done(nb, sd);
        n_checks += 3;
        if (nb !== W || sd !== 1'b1) begin n_fail++; $display("FAIL rst_after_latency busy %0d done %b want %0d 1", nb, sd, W); end
        if (quotient !== 8'd3) begin n_fail++; $display("FAIL rst_after_quo got %h want 03", quotient); end
        if (remainder !== 8'd0) begin n_fail++; $display("FAIL rst_after_rem got %h want 00", remainder); end
    endtask

    task automatic test_signed();
`ifdef SEQ_DIVIDER_SIGNED_EN
        logic [W-1:0] us [8] = '{8'hF9, 8'h07, 8'h80, 8'hF9, 8'h07, 8'h80, 8'hF9, 8'h80};
        logic [W-1:0] vs [8] = '{8'h02, 8'hFE, 8'hFF, 8'h02, 8'hFE, 8'hFF, 8'h00, 8'h03};
        logic         ss [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] eq, er;
        logic ez, sd;
        int nb;
        for (int i = 0; i < 8; i++) begin
            ref_div(us[i], vs[i], ss[i], eq, er, ez);
            start_op(us[i], vs[i], ss[i]);
            wait_done(nb, sd);
            n_checks += 4;
            if (nb !== W || sd !== 1'b1) begin n_fail++; $display("FAIL sgn%0d_latency busy %0d done %b", i, nb, sd); end
            if (quotient !== eq) begin n_fail++; $display("FAIL sgn%0d_quo got %h want %h", i, quotient, eq); end
            if (remainder !== er) begin n_fail++; $display("FAIL sgn%0d_rem got %h want %h", i, remainder, er); end
            if (div_by_zero !== ez) begin n_fail++; $display("FAIL sgn%0d_dbz got %b want %b", i, div_by_zero, ez); end
        end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] u, v, eq, er;
        logic s, ez, sd;
        int nb;
        for (int i = 0; i < 40; i++) begin
            u = W'($urandom);
            v = (i % 7 == 0) ? '0 : ((i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom));
`ifdef SEQ_DIVIDER_SIGNED_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            ref_div(u, v, s, eq, er, ez);
            start_op(u, v, s);
            wait_done(nb, sd);
            n_checks += 4;
            if (nb !== W || sd !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_latency busy %0d done %b", i, nb, sd); end
            if (quotient !== eq) begin n_fail++; $display("FAIL rnd%0d_quo %h/%h s=%b got %h want %h", i, u, v, s, quotient, eq); end
            if (remainder !== er) begin n_fail++; $display("FAIL rnd%0d_rem %h/%h s=%b got %h want %h", i, u, v, s, remainder, er); end
            if (div_by_zero !== ez) begin n_fail++; $display("FAIL rnd%0d_dbz got %b want %b", i, div_by_zero, ez); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_reset_midop();
        test_signed();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised sequential restoring divider: accepts a WIDTH-bit dividend and divisor on a start/busy handshake, produces quotient, remainder and a divide-by-zero flag after a fixed WIDTH-cycle latency. Next generation of the team's repeated-subtraction divider. Latency is data-independent, inputs are captured on start rather than a free-running load, and completion is signalled explicitly. Sits between operand sources (switch/CPU registers) and result consumers (7-segment display path, register read-back).

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a division; accepted only when busy = 0.
- dividend  in  WIDTH  dividend (u); sampled on the accepting edge only.
- divisor  in  WIDTH  divisor (v); sampled on the accepting edge only.
- busy  out  1  division in progress; start is ignored while high.
- done  out  1  one-cycle pulse: quotient/remainder/div_by_zero valid from this cycle.
- quotient  out  WIDTH  result; held until the next completion.
- remainder  out  WIDTH  result; held until the next completion.
- div_by_zero  out  1  divisor was 0 for the last completed operation; held like the results.
- is_signed  in  1  present only with SEQ_DIVIDER_SIGNED_EN; sampled with operands.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: busy=0, done=0. start=1 -> latch operands, partial remainder=0, step counter=WIDTH-1 -> CALC.
- CALC: busy=1. Each edge performs one restoring step:
  - shift {rem, quo} left one bit, bringing in the dividend MSB;
  - trial = rem - divisor, computed WIDTH+1 bits wide;
  - if trial is non-negative, rem=trial and quotient bit=1; otherwise quotient bit=0.
  - Counter decrements each step. At counter=0, the result registers are written on that edge -> DONE.
- DONE: busy=0, done=1 for exactly one cycle -> IDLE. A start in DONE is accepted exactly as in IDLE (back-to-back operation).
- start while busy=1: ignored; operand inputs are don't-care.
- Divisor 0: no special path and the same latency. Result is quotient = all ones and remainder = dividend, with div_by_zero=1.
- Results change only on the completing edge and are otherwise held.
- Reset in any state:
  - state returns to IDLE; the in-flight operation is discarded;
  - busy, done, div_by_zero return to 0;
  - quotient and remainder return to 0.

## Timing
- Accepting edge k: busy=1 from edge k to edge k+WIDTH, i.e. WIDTH cycles.
- Results written and done=1 after edge k+WIDTH. Latency is WIDTH clocks from acceptance to done.
- Maximum throughput is one operation per WIDTH+1 cycles, with start held or re-asserted during done.
- No combinational path from inputs to outputs.

## Configuration
- SEQ_DIVIDER_SIGNED_EN defined:
  - Adds the is_signed port.
  - When is_signed=1, operands are two's complement. Magnitudes are divided and signs fixed on the completing edge, so latency is unchanged.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Most-negative / -1 gives quotient = most-negative (wrap) and remainder = 0.
  - Divide-by-zero results are the unsigned-mode values, with div_by_zero=1.
- SEQ_DIVIDER_SIGNED_EN not defined: no is_signed port; unsigned-only behaviour as above.

## Structure
- Package seq_divider_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the WIDTH limits (minimum 2, maximum 32);
  - the default WIDTH constant.
- Step counter width is $clog2(WIDTH).
- One sub-module, div_step: a combinational single restoring step. It takes the partial remainder, next dividend bit and divisor, and produces the new partial remainder and the quotient bit. The top module owns the registers and FSM.

## Test plan
- WIDTH=8, 100/7 -> quotient=14, remainder=2, div_by_zero=0. busy high 8 cycles, done one cycle after the 8th step edge.
- 5/0 -> quotient=0xFF, remainder=5, div_by_zero=1, same 8-cycle latency. Then 0/3 -> 0, 0, div_by_zero cleared.
- 255/1 -> 255, 0. 7/9 -> 0, 7. Start re-asserted during done -> next operation accepted with no idle gap.
- start pulsed mid-CALC with different operands -> ignored; original result unchanged.
- reset asserted at step 4 -> busy, done, results all 0 immediately. A following 9/3 -> 3, 0 normally.
- SEQ_DIVIDER_SIGNED_EN, is_signed=1:
  - -7/2 -> 0xFD, 0xFF;
  - 7/-2 -> 0xFD, 0x01;
  - -128/-1 -> 0x80, 0x00.
  - Same operands with is_signed=0 -> unsigned results.
